// File: rtl/mem_pkg.sv
// Shared types for the memory controller: FSM states and fault-cause codes.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_RANGE    = 2'd1,
        FLT_ALIGN    = 2'd2,
        FLT_FETCH_WR = 2'd3
    } fault_e;

    // First matching cause wins; range is reported ahead of alignment.
    function automatic fault_e classify_fault(input logic in_range,
                                              input logic misaligned,
                                              input logic fetch_wr);
        fault_e cause;
        cause = FLT_NONE;
        if (!in_range) begin
            cause = FLT_RANGE;
        end else if (misaligned) begin
            cause = FLT_ALIGN;
        end else if (fetch_wr) begin
            cause = FLT_FETCH_WR;
        end
        return cause;
    endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port
// that returns zero on cycles without a read.
module mem_sram_bank
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     addr,
    input  logic              re,
    input  logic [LANES-1:0]  we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [LANES-1:0][7:0] ram [DEPTH];
    logic [WORD_W-1:0]     rdata_q;
    logic [WORD_W-1:0]     rdata_d;

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                ram[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = ram[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Wait-stated memory controller: latches one core request, decodes faults,
// and returns a single-cycle mem_ready pulse with read data or fault status.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_fault
);

    localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW         = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    fault_e        cause_q, cause_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    logic [31:0]   offset_c;
    logic [AW-1:0] in_idx_c;
    fault_e        in_cause_c;
    logic [AW-1:0] ram_addr_c;
    logic          ram_re_c;
    logic [3:0]    ram_we_c;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
    assign offset_c   = mem_addr - BASE_ADDR;
    assign in_idx_c   = offset_c[AW+1:2];
    assign in_cause_c = classify_fault(offset_c < SPAN_BYTES,
                                       mem_addr[1:0] != 2'b00,
                                       mem_instr && (mem_wstrb != 4'h0));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cause_d    = cause_q;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        ram_addr_c = idx_q;
        ram_re_c   = 1'b0;
        ram_we_c   = 4'h0;

        case (state_q)
            ST_IDLE: begin
                ram_addr_c = in_idx_c;
                if (mem_valid) begin
                    idx_d   = in_idx_c;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cause_d = in_cause_c;
                    cnt_d   = CW'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        fault_d  = (in_cause_c != FLT_NONE);
                        ram_re_c = (mem_wstrb == 4'h0) && (in_cause_c == FLT_NONE);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b1;
                    fault_d  = (cause_q != FLT_NONE);
                    ram_re_c = (wstrb_q == 4'h0) && (cause_q == FLT_NONE);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                // Write commits on the edge leaving DONE so a reset there drops it.
                if ((cause_q == FLT_NONE) && !reset) begin
                    ram_we_c = wstrb_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cause_q <= cause_d;
        end
    end

    mem_sram_bank #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .addr  (ram_addr_c),
        .re    (ram_re_c),
        .we    (ram_we_c),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign mem_ready = ready_q;
    assign mem_fault = fault_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the RAM.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before mem_ready (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_valid  input  1  core request pending.
REQ-007 SHALL have port mem_instr  input  1  request is an instruction fetch.
REQ-008 SHALL have port mem_addr  input  32  byte address.
REQ-009 SHALL have port mem_wdata  input  32  write data.
REQ-010 SHALL have port mem_wstrb  input  4  byte-write enables; 0 means read.
REQ-011 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_rdata  output  32  read data, valid while mem_ready is high.
REQ-013 SHALL have port mem_fault  output  1  request rejected, valid while mem_ready is high.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 IDLE: mem_valid high -> latch addr/wdata/wstrb/instr and load the wait counter with WAIT_STATES; go to WAIT if WAIT_STATES>0, else DONE.
REQ-016 WAIT: decrement the counter each cycle; at 1 go to DONE.
REQ-017 DONE: assert mem_ready for exactly one cycle, then go to IDLE.
REQ-018 Latency: mem_ready SHALL rise exactly WAIT_STATES+1 cycles after the first cycle in which mem_valid is sampled high in IDLE.
REQ-019 After mem_ready, at least one IDLE cycle SHALL pass before the next request is latched, so back-to-back throughput is one request per WAIT_STATES+2 cycles.
REQ-020 Request is in range iff (mem_addr - BASE_ADDR) < DEPTH_WORDS*4, computed unsigned 32-bit, so addresses below BASE_ADDR wrap to out of range.
REQ-021 Fault SHALL be asserted for out-of-range, mem_addr[1:0]!=0, or mem_instr=1 with mem_wstrb!=0.
REQ-022 Faulting request: same latency, mem_fault=1, mem_rdata=0, RAM unmodified.
REQ-023 Read (wstrb==0, no fault): mem_rdata = word at index (mem_addr-BASE_ADDR)>>2.
REQ-024 Write: in the DONE cycle, each byte lane i with wstrb[i]=1 takes wdata[8i+7:8i]; other lanes keep their value; mem_rdata=0.
REQ-025 A read issued right after a write to the same word SHALL return the written data.
REQ-026 Latched request values SHALL be used throughout; changes to inputs or mem_valid dropping after latch SHALL NOT alter or abort the transaction.
REQ-027 mem_rdata and mem_fault SHALL be 0 whenever mem_ready is 0.

Reset
REQ-028 reset SHALL force state IDLE, counter 0, mem_ready=0, mem_rdata=0, mem_fault=0 on the next clock edge.
REQ-029 Reset in WAIT or DONE SHALL abort the transaction with no RAM write committed and no mem_ready pulse.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 State enum and fault-cause encoding SHALL live in shared package mem_pkg.
REQ-032 The byte-lane RAM SHALL be the sub-module mem_sram_bank (one synchronous read/write port, per-byte write enables); FSM, decode and counter stay in mem_ctrl.
REQ-033 Counter width SHALL be $clog2(WAIT_STATES+1), minimum 1.

Verification
REQ-034 WAIT_STATES=1, write 0xDEADBEEF wstrb=4'hF to 0x10, then read 0x10 -> ready 2 cycles after valid each time, rdata=0xDEADBEEF, fault=0.
REQ-035 Word 0x20 = 0x11223344, write 0xAABBCCDD wstrb=4'b0101, then read -> 0x11BB33DD.
REQ-036 Read 0x0000_1000 with DEPTH_WORDS=1024 -> ready with fault=1, rdata=0; read 0x2 -> fault=1.
REQ-037 Fetch with mem_instr=1, wstrb=4'h1 -> fault=1, RAM word unchanged on re-read.
REQ-038 Reset asserted in the WAIT cycle of a write -> no ready pulse, and a following read returns the old value.
REQ-039 WAIT_STATES=0 with mem_valid held high -> ready every 2nd cycle, each pulse exactly one cycle wide.
